uart_rx: RTL
============

# uart_rx

Oversampling UART receiver. It is the downstream counterpart of the UART transmitter and recovers the transmitter's frame format: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1. It turns the serial line back into parallel bytes, with per-frame parity and stop-bit error flags. It runs in the transmitter's clock domain with a programmable oversampling ratio. For loopback, the transmitter is stepped once per PRESCALE clocks.

## Interface
Parameters:
- DATA_W, 8, data bits per frame (fixed at 8 for this release)
- PRESCALE_W, 5, width of PRESCALE port

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, idle high, asynchronous to clk
- PRESCALE  input  5  clocks per bit; legal 4..31; static while RX_BUSY=1
- PAR_EN  input  1  1 = frame carries a parity bit
- PAR_TYP  input  1  0: expected parity = ~^data; 1: expected parity = ^data
- P_DATA  output  8  last received byte
- DATA_VALID  output  1  one-cycle pulse, P_DATA valid
- PAR_ERR  output  1  one-cycle pulse, parity mismatch
- STP_ERR  output  1  one-cycle pulse, stop bit sampled 0
- RX_BUSY  output  1  high whenever state is not IDLE

## Operation
- **Reset values:** P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, RX_BUSY=0. State=IDLE, counters=0. Both synchronizer flops=1, previous-sample flop=1.
- **Synchronizer:** RX_IN passes a 2-flop synchronizer giving rx_s. A prev flop holds the last rx_s.
- **Counters:** H = PRESCALE>>1. edge_cnt counts 0..PRESCALE-1 within each bit. bit_cnt counts 0..7 in DATA.
- **Bit value:** majority of rx_s at edge_cnt = H-1, H and H+1. It is decided combinationally in the edge_cnt=H+1 cycle (the "decision cycle").
- **States:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** a falling edge (prev=1, rx_s=0) marks sample 0 of the start bit. Next state is START with edge_cnt=1. PAR_EN and PAR_TYP are latched on this transition.
  - **START:** if the decision is 1, the start was a glitch: go to IDLE at the next edge, with no flags. Otherwise, at edge_cnt=PRESCALE-1, go to DATA with edge_cnt=0 and bit_cnt=0.
  - **DATA:** on each decision, shift the bit into the shift register at position bit_cnt. At edge_cnt=PRESCALE-1 with bit_cnt=7, go to PARITY if the latched PAR_EN=1, else go to STOP.
  - **PARITY:** on the decision, compare against the expected parity of the shift register using the latched PAR_TYP. Store the mismatch internally. At edge_cnt=PRESCALE-1, go to STOP.
  - **STOP:** on the decision cycle, go to IDLE at the next edge, without waiting for the end of the bit. Outputs registered on that same edge:
    - stop bit 1 and no mismatch: P_DATA = shift register, DATA_VALID=1
    - mismatch: PAR_ERR=1, no DATA_VALID, P_DATA unchanged
    - stop bit 0: STP_ERR=1, no DATA_VALID; PAR_ERR may assert in the same cycle
- **Flag width:** DATA_VALID, PAR_ERR and STP_ERR are high exactly one cycle per frame.
- **Line held low:** after a stop error, IDLE requires rx_s to return to 1 before a new falling edge is accepted. A break therefore never re-triggers the receiver.
- **Reset mid-frame:** state returns to IDLE immediately and no flags are produced. The partial byte is discarded.

## Timing
- Let edge e0 be the first clk edge that samples RX_IN=0, and N the frame length (10 bits, or 11 with parity).
- DATA_VALID (or the error flag) is high in the cycle after edge e0 + (N-1)·PRESCALE + H + 3.
- RX_BUSY rises after edge e0+2. It falls on the same edge the flags assert.
- The receiver rearms about half a bit before the nominal stop end. Back-to-back frames with a one-bit stop are received without loss.
- Receiver tolerance is ±(H-2)/PRESCALE of a bit, accumulated over the frame.

## Test plan
- **Basic byte:** PRESCALE=8, PAR_EN=0, byte 0xA5 driven at 8 clk/bit.
  - Expect DATA_VALID in the cycle after e0+79, P_DATA=0xA5, no error flags.
- **Parity pass/fail:** PRESCALE=16, PAR_EN=1, PAR_TYP=0, byte 0x03.
  - Parity bit 1: DATA_VALID, P_DATA=0x03.
  - Parity bit 0: PAR_ERR pulse only, P_DATA holds its previous value.
- **Start glitch:** PRESCALE=8, RX_IN low for 2 clk then high.
  - RX_BUSY pulses, then IDLE; no DATA_VALID or error flags.
  - A following valid 0x5A frame is received correctly.
- **Stop error and break:** PRESCALE=8, frame 0xFF with stop bit 0, then line held low 100 clk.
  - Single STP_ERR pulse, no DATA_VALID.
  - No further activity until the line returns high and falls again.
- **Back-to-back:** 16 consecutive frames at PRESCALE=4 with one-bit stop, random bytes, PAR_EN=1, PAR_TYP=1.
  - Expect 16 DATA_VALID pulses with matching bytes.
- **Reset mid-frame:** reset low for 1 clk during DATA bit 4.
  - All outputs return to their reset values with no flags.
  - The next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, majority-vote bit decision,
// optional parity, one-cycle DATA_VALID / PAR_ERR / STP_ERR pulses.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle, waiting for a falling edge on the synchronized line
// ST_START  | start bit; a decision of 1 means a glitch, so drop back to idle
// ST_DATA   | eight data bits, LSB first, one decision per bit
// ST_PARITY | parity bit, mismatch remembered until the stop decision
// ST_STOP   | stop bit; the decision ends the frame and posts the flags
module uart_rx #(
   parameter int DATA_W     = 8,
   parameter int PRESCALE_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  RX_IN,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_W-1:0]     P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR,
   output logic                  RX_BUSY
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
   localparam logic [2:0]            LAST_BIT = 3'(DATA_W - 1);

   state_t                  r_state;
   logic [1:0]              r_sync;
   logic                    r_prev;
   logic [PRESCALE_W-1:0]   r_edge_cnt;
   logic [2:0]              r_bit_cnt;
   logic [DATA_W-1:0]       r_shift;
   logic                    r_smp0;
   logic                    r_smp1;
   logic                    r_pen;
   logic                    r_ptyp;
   logic                    r_perr;

   logic                    w_rx_s;
   logic [PRESCALE_W-1:0]   w_half;
   logic [PRESCALE_W-1:0]   w_half_m1;
   logic [PRESCALE_W-1:0]   w_half_p1;
   logic [PRESCALE_W-1:0]   w_last;
   logic                    w_decide;
   logic                    w_end;
   logic                    w_bit;
   logic                    w_par_exp;

   assign w_rx_s    = r_sync[1];
   assign w_half    = PRESCALE >> 1;
   assign w_half_m1 = w_half - ONE;
   assign w_half_p1 = w_half + ONE;
   assign w_last    = PRESCALE - ONE;
   assign w_decide  = (r_edge_cnt == w_half_p1);
   assign w_end     = (r_edge_cnt == w_last);
   // third sample is taken live in the decision cycle
   assign w_bit     = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);
   assign w_par_exp = r_ptyp ? (^r_shift) : (~^r_shift);
   assign RX_BUSY   = (r_state != ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= 2'b11;
         r_prev <= 1'b1;
      end else begin
         r_sync <= {r_sync[0], RX_IN};
         r_prev <= w_rx_s;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_edge_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_smp0     <= 1'b1;
         r_smp1     <= 1'b1;
         r_pen      <= 1'b0;
         r_ptyp     <= 1'b0;
         r_perr     <= 1'b0;
         P_DATA     <= '0;
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;
      end else begin
         DATA_VALID <= 1'b0;
         PAR_ERR    <= 1'b0;
         STP_ERR    <= 1'b0;

         if (r_state != ST_IDLE) begin
            if (r_edge_cnt == w_half_m1) r_smp0 <= w_rx_s;
            if (r_edge_cnt == w_half)    r_smp1 <= w_rx_s;
         end

         case (r_state)
            ST_IDLE: begin
               // the falling-edge cycle itself is sample 0 of the start bit
               if (r_prev && !w_rx_s) begin
                  r_state    <= ST_START;
                  r_edge_cnt <= ONE;
                  r_pen      <= PAR_EN;
                  r_ptyp     <= PAR_TYP;
                  r_perr     <= 1'b0;
               end
            end

            ST_START: begin
               if (w_decide && w_bit) begin
                  r_state    <= ST_IDLE;
                  r_edge_cnt <= '0;
               end else if (w_end) begin
                  r_state    <= ST_DATA;
                  r_edge_cnt <= '0;
                  r_bit_cnt  <= '0;
               end else begin
                  r_edge_cnt <= r_edge_cnt + ONE;
               end
            end

            ST_DATA: begin
               if (w_decide) r_shift[r_bit_cnt] <= w_bit;
               if (w_end) begin
                  r_edge_cnt <= '0;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_bit_cnt <= '0;
                     r_state   <= r_pen ? ST_PARITY : ST_STOP;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end else begin
                  r_edge_cnt <= r_edge_cnt + ONE;
               end
            end

            ST_PARITY: begin
               if (w_decide) r_perr <= (w_bit != w_par_exp);
               if (w_end) begin
                  r_state    <= ST_STOP;
                  r_edge_cnt <= '0;
               end else begin
                  r_edge_cnt <= r_edge_cnt + ONE;
               end
            end

            ST_STOP: begin
               // leave before the bit ends so back-to-back starts are not missed
               if (w_decide) begin
                  r_state    <= ST_IDLE;
                  r_edge_cnt <= '0;
                  if (!w_bit) begin
                     STP_ERR <= 1'b1;
                     PAR_ERR <= r_perr;
                  end else if (r_perr) begin
                     PAR_ERR <= 1'b1;
                  end else begin
                     P_DATA     <= r_shift;
                     DATA_VALID <= 1'b1;
                  end
               end else begin
                  r_edge_cnt <= r_edge_cnt + ONE;
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_edge_cnt <= '0;
            end
         endcase
      end
   end

endmodule
